// File: rtl/record_serializer_if.sv
// Record/byte stream bundle for record_serializer.
//
// Signals
//   data_in         record; payload byte 0 sits in the top 8 bits (data_in[REC_W-1 -: 8]),
//                   so the first record bit is the MSB of the first payload byte
//   data_in_val     record valid
//   data_in_ready   serializer can accept a record
//   packet_lost     sequence-gap flag travelling with data_in
//   byte_out        serialized byte
//   byte_out_val    byte_out valid
//   byte_out_ready  sink accepts byte
//   byte_out_last   final payload byte of a frame
//
// Modports
//   master  record producer and byte sink (the environment around the serializer)
//   slave   the serializer itself
interface record_serializer_if #(
  parameter int unsigned REC_W = 296
);
  logic [REC_W-1:0] data_in;
  logic             data_in_val;
  logic             data_in_ready;
  logic             packet_lost;
  logic [7:0]       byte_out;
  logic             byte_out_val;
  logic             byte_out_ready;
  logic             byte_out_last;

  modport master (
    output data_in,
    output data_in_val,
    output packet_lost,
    output byte_out_ready,
    input  data_in_ready,
    input  byte_out,
    input  byte_out_val,
    input  byte_out_last
  );

  modport slave (
    input  data_in,
    input  data_in_val,
    input  packet_lost,
    input  byte_out_ready,
    output data_in_ready,
    output byte_out,
    output byte_out_val,
    output byte_out_last
  );
endinterface

// File: rtl/record_serializer.sv
// Record serializer: buffers complete records with their packet-lost flag in a small FIFO and
// emits each one as a frame of one status byte ({7'b0, lost}) followed by REC_W/8 payload bytes
// on a byte-wide valid/ready stream. Also keeps a saturating count of lost packets.
//
// Ports
//   clk         clock
//   reset_b     asynchronous active-low reset
//   bus         record input / byte output handshakes (record_serializer_if.slave)
//   lost_count  accepted records that carried packet_lost=1, saturating at all-ones
//   fifo_level  occupied FIFO entries
//
// Timing: a record pushed into an empty, idle serializer shows its status byte in the very next
// cycle. Frames follow each other without idle cycles while the FIFO holds entries.
module record_serializer #(
  parameter int unsigned DEPTH = 4,    // power of two, >= 2
  parameter int unsigned REC_W = 296,  // multiple of 8
  parameter int unsigned CNT_W = 16,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_b,
  record_serializer_if.slave   bus,
  output logic [CNT_W-1:0]     lost_count,
  output logic [LVL_W-1:0]     fifo_level
);

  localparam int unsigned NBYTES = REC_W / 8;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned ENT_W  = REC_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StStatus,
    StData
  } state_e;

  // FIFO storage: entry = {lost, record}
  logic [ENT_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wptr_q, rptr_q, rptr_nxt;
  logic [LVL_W-1:0] level_q;
  logic [CNT_W-1:0] count_q;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [7:0]       byte_q;
  logic             val_q;
  logic             last_q;

  logic             full;
  logic             push;
  logic             pop;
  logic             more;
  logic             next_lost;
  logic [ENT_W-1:0] head;
  logic [REC_W-1:0] head_data;
  logic [REC_W-1:0] head_shift;
  logic [7:0]       byte0;
  logic [7:0]       byte_nxt;

  // Input side. Full refuses the push even if the head frame finishes this same cycle.
  assign full               = (level_q == LVL_W'(DEPTH));
  assign bus.data_in_ready  = ~full;
  assign push               = bus.data_in_val & ~full;

  // Pop only on the final payload handshake of a legal DATA state with something stored.
  assign pop = val_q & last_q & bus.byte_out_ready & (state_q == StData) & (level_q != '0);

  assign rptr_nxt  = rptr_q + PTR_W'(1);
  assign head      = mem[rptr_q];
  assign head_data = head[REC_W-1:0];
  assign idx_nxt   = idx_q + IDX_W'(1);

  // Payload byte i is the i-th byte counted from the top of the record.
  assign byte0      = head_data[REC_W-1 -: 8];
  assign head_shift = head_data << {idx_nxt, 3'b000};
  assign byte_nxt   = head_shift[REC_W-1 -: 8];

  // Another frame follows the current one if a second entry is stored or one is being pushed
  // right now; with a single stored entry the follower's flag is still on the input bus.
  assign more      = (level_q > LVL_W'(1)) | push;
  assign next_lost = (level_q > LVL_W'(1)) ? mem[rptr_nxt][REC_W] : bus.packet_lost;

  assign bus.byte_out      = byte_q;
  assign bus.byte_out_val  = val_q;
  assign bus.byte_out_last = last_q;
  assign lost_count        = count_q;
  assign fifo_level        = level_q;

  // Storage is never reset; level and pointers decide what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= {bus.packet_lost, bus.data_in};
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_q <= rptr_nxt;
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      if (push && bus.packet_lost && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Frame sequencer. All stream outputs are registered and only change on a handshake (or when
  // leaving IDLE), so they hold steady through sink stalls.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= StIdle;
      idx_q   <= '0;
      byte_q  <= '0;
      val_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if ((level_q != '0) || push) begin
            // A push into an empty FIFO is forwarded straight to the status byte.
            state_q <= StStatus;
            byte_q  <= {7'b0, (level_q != '0) ? head[REC_W] : bus.packet_lost};
            val_q   <= 1'b1;
            last_q  <= 1'b0;
            idx_q   <= '0;
          end
        end
        StStatus: begin
          if (bus.byte_out_ready) begin
            state_q <= StData;
            idx_q   <= '0;
            byte_q  <= byte0;
            last_q  <= (NBYTES == 1);
          end
        end
        StData: begin
          if (bus.byte_out_ready) begin
            if (last_q) begin
              idx_q  <= '0;
              last_q <= 1'b0;
              if (more) begin
                state_q <= StStatus;
                byte_q  <= {7'b0, next_lost};
              end else begin
                state_q <= StIdle;
                byte_q  <= '0;
                val_q   <= 1'b0;
              end
            end else begin
              idx_q  <= idx_nxt;
              byte_q <= byte_nxt;
              last_q <= (idx_nxt == IDX_W'(NBYTES - 1));
            end
          end
        end
        default: begin
          // Unreachable encoding: drop the stream, leave the FIFO alone.
          state_q <= StIdle;
          idx_q   <= '0;
          byte_q  <= '0;
          val_q   <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_record_serializer.sv
// Self-checking bench for record_serializer: stimulus pushes expected frame bytes into a
// scoreboard queue when a record is accepted; a monitor pops and compares on every byte
// handshake and tracks expected occupancy, lost count and stream validity each cycle.
module tb_record_serializer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned REC_W  = 296;
  localparam int unsigned NBYTES = REC_W / 8;
  localparam int unsigned CNT_W  = 16;

  logic clk = 1'b0;
  logic reset_b = 1'b1;
  always #5 clk = ~clk;

  record_serializer_if #(.REC_W(REC_W)) bus ();
  record_serializer_if #(.REC_W(REC_W)) bus2 ();

  logic [CNT_W-1:0] lost_count;
  logic [2:0]       fifo_level;
  logic [3:0]       lost_count2;
  logic [2:0]       fifo_level2;

  record_serializer #(.DEPTH(DEPTH), .REC_W(REC_W), .CNT_W(CNT_W)) u_dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .bus        (bus),
    .lost_count (lost_count),
    .fifo_level (fifo_level)
  );

  // Narrow counter copy to reach saturation in a short run.
  record_serializer #(.DEPTH(DEPTH), .REC_W(REC_W), .CNT_W(4)) u_dut_sat (
    .clk        (clk),
    .reset_b    (reset_b),
    .bus        (bus2),
    .lost_count (lost_count2),
    .fifo_level (fifo_level2)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q [$];       // {last, byte}
  int         exp_level = 0;   // records accepted but not yet fully sent
  int         model_lost = 0;
  int         frame_bytes = 0;
  logic       saw_full_pop = 1'b0;
  logic [7:0] pay [NBYTES];

  logic       rand_ready = 1'b0;
  logic       sink_ready = 1'b1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Sink ready has a single driver.
  always @(posedge clk) begin
    #1;
    bus.byte_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : sink_ready;
  end

  // Monitor: samples at the falling edge, where inputs are stable for the next rising edge.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = '0;
  logic       prev_last  = 1'b0;

  always @(negedge clk) begin
    if (!reset_b) begin
      exp_q.delete();
      exp_level   = 0;
      model_lost  = 0;
      frame_bytes = 0;
      prev_stall  = 1'b0;
    end else begin
      check("data_in_ready", 32'(bus.data_in_ready), 32'(exp_level < DEPTH));
      check("fifo_level", 32'(fifo_level), 32'(exp_level));
      check("byte_out_val", 32'(bus.byte_out_val), 32'(exp_level != 0));
      check("lost_count", 32'(lost_count), 32'(model_lost));
      if (prev_stall) begin
        check("hold_byte", 32'(bus.byte_out), 32'(prev_byte));
        check("hold_last", 32'(bus.byte_out_last), 32'(prev_last));
      end
      if (bus.byte_out_val && bus.byte_out_ready) begin
        frame_bytes++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(bus.byte_out), 32'hFFFF_FFFF);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("byte_out", 32'(bus.byte_out), 32'(e[7:0]));
          check("byte_out_last", 32'(bus.byte_out_last), 32'(e[8]));
          if (e[8]) begin
            check("frame_len", 32'(frame_bytes), 32'(NBYTES + 1));
            frame_bytes = 0;
            if (exp_level == DEPTH && bus.data_in_val) saw_full_pop = 1'b1;
            exp_level--;
          end
        end
      end
      if (bus.data_in_val && bus.data_in_ready) begin
        exp_level++;
        if (bus.packet_lost && model_lost < 65535) model_lost++;
      end
      prev_stall = bus.byte_out_val && !bus.byte_out_ready;
      prev_byte  = bus.byte_out;
      prev_last  = bus.byte_out_last;
    end
  end

  task automatic gen_rec();
    for (int i = 0; i < NBYTES; i++) pay[i] = 8'($urandom);
  endtask

  // Called just after a rising edge; returns just after the accepting rising edge with
  // data_in_val low, so consecutive calls give back-to-back pushes.
  task automatic push_rec(input logic lost);
    logic [REC_W-1:0] rec;
    int   waited;
    logic ok;
    rec = '0;
    for (int i = 0; i < NBYTES; i++) rec = {rec[REC_W-9:0], pay[i]};
    bus.data_in     = rec;
    bus.packet_lost = lost;
    bus.data_in_val = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited < 3000) begin
      @(negedge clk);
      if (bus.data_in_ready) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      check("push_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back({1'b0, 7'b0, lost});
      for (int i = 0; i < NBYTES; i++) exp_q.push_back({(i == NBYTES - 1), pay[i]});
    end
    @(posedge clk);
    #1;
    bus.data_in_val = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_level != 0 || exp_q.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 5000), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    bus.data_in      = '0;
    bus.data_in_val  = 1'b0;
    bus.packet_lost  = 1'b0;
    bus2.data_in     = '0;
    bus2.data_in_val = 1'b0;
    bus2.packet_lost = 1'b1;
    bus2.byte_out_ready = 1'b1;

    // Reset values
    #1 reset_b = 1'b0;
    #2;
    check("rst_val", 32'(bus.byte_out_val), 32'd0);
    check("rst_last", 32'(bus.byte_out_last), 32'd0);
    check("rst_byte", 32'(bus.byte_out), 32'd0);
    check("rst_ready", 32'(bus.data_in_ready), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_count", 32'(lost_count), 32'd0);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single record 01..25, ready high
    for (int i = 0; i < NBYTES; i++) pay[i] = 8'(i + 1);
    push_rec(1'b0);
    drain();
    check("t1_lost_count", 32'(lost_count), 32'd0);

    // 2: four records into a stalled sink, then release
    sink_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) begin
      gen_rec();
      push_rec(1'((r + 1) % 2));
    end
    repeat (3) @(posedge clk);
    #1;
    check("t2_level", 32'(fifo_level), 32'd4);
    check("t2_ready", 32'(bus.data_in_ready), 32'd0);
    check("t2_lost", 32'(lost_count), 32'd2);
    sink_ready = 1'b1;
    drain();

    // 3: random sink stalls with random records and gaps
    rand_ready = 1'b1;
    for (int r = 0; r < 10; r++) begin
      gen_rec();
      push_rec(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();
    rand_ready = 1'b0;

    // 4: full FIFO, a fifth record waits while the head frame finishes
    sink_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) begin
      gen_rec();
      push_rec(1'b0);
    end
    gen_rec();
    fork
      push_rec(1'b1);
      begin
        repeat (4) @(posedge clk);
        sink_ready = 1'b1;
      end
    join
    drain();
    check("t4_full_pop_seen", 32'(saw_full_pop), 32'd1);

    // 5: saturation on the narrow-counter instance (4-bit counter, 20 lost pushes)
    acc = 0;
    n = 0;
    bus2.data_in_val = 1'b1;
    while (acc < 20 && n < 6000) begin
      @(negedge clk);
      n++;
      check("t5_sat_count", 32'(lost_count2), 32'((acc > 15) ? 15 : acc));
      if (bus2.data_in_val && bus2.data_in_ready) acc++;
      if (acc == 20) bus2.data_in_val = 1'b0;
    end
    bus2.data_in_val = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_sat_final", 32'(lost_count2), 32'd15);
    check("t5_acc", 32'(acc), 32'd20);

    // 6: reset in the middle of a frame
    @(posedge clk);
    #1;
    gen_rec();
    push_rec(1'b1);
    n = 0;
    while (frame_bytes < 10 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("t6_reach_byte10", 32'(frame_bytes >= 10), 32'd1);
    @(posedge clk);
    #3;
    reset_b = 1'b0;
    #1;
    check("t6_async_val", 32'(bus.byte_out_val), 32'd0);
    check("t6_async_level", 32'(fifo_level), 32'd0);
    check("t6_async_last", 32'(bus.byte_out_last), 32'd0);
    check("t6_async_count", 32'(lost_count), 32'd0);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    // Recovery after reset
    gen_rec();
    push_rec(1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
